sobel_edge_detection: RTL and testbench
=======================================

SOBEL_EDGE_DETECTION -- requirements
Module: sobel_edge_detection

Interface
REQ-001 SHALL have parameter KEY_CNT_MAX, default 500000, meaning debounce stable-count in clk cycles (benches override to 100).
REQ-002 SHALL have parameter SCCB_DIV, default 250, meaning clk cycles per SCCB bit period (100 kHz at 25 MHz).
REQ-003 SHALL have parameter EDGE_TH, default 100, meaning the Sobel magnitude threshold.
REQ-004 SHALL have port clk  input  1  system clock, 25 MHz, also used as camera pixel clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_in  input  1  push button, active-low.
REQ-007 SHALL have port vsync  input  1  camera frame sync, high between frames.
REQ-008 SHALL have port href  input  1  camera line-valid.
REQ-009 SHALL have port din  input  8  camera data, YUV422 bytes Y,U,Y,V,...
REQ-010 SHALL have port xclk  output  1  camera master clock, equal to clk.
REQ-011 SHALL have port sio_c  output  1  SCCB clock.
REQ-012 SHALL have port sio_d  output  1  SCCB data, write-only.
REQ-013 SHALL have port vga_hys  output  1  output pixel-valid, aligned to vga_rgb.
REQ-014 SHALL have port vga_vys  output  1  output frame sync, vsync delayed by the pipeline latency.
REQ-015 SHALL have port vga_rgb  output  16  RGB565 edge pixel.

Function
REQ-016 SHALL debounce key_in: one-cycle press pulse once key_in held low for KEY_CNT_MAX consecutive cycles; one pulse per press; counter restarts on any bounce.
REQ-017 SHALL start SCCB configuration on a press pulse if idle; presses during configuration SHALL be ignored.
REQ-018 SHALL write an internal table of 8 register/value pairs as 3-phase writes: start, ID 0x42, reg, value, stop; don't-care bit driven 1.
REQ-019 SHALL drive sio_c/sio_d idle high; sio_d changes only while sio_c is low; start/stop as SDA falling/rising with SCL high.
REQ-020 SHALL set an internal cfg_done flag after the last table write; flag never clears except by reset.
REQ-021 SHALL enable capture at the first vsync falling edge after cfg_done; frames before that produce vga_hys=0.
REQ-022 SHALL take every even byte (Y) while href=1, line width 640 Y samples; column counter resets when href falls; row counter resets on vsync.
REQ-023 SHALL buffer two previous lines (two 640x8 line RAMs) and form a 3x3 window.
REQ-024 SHALL compute Gx=(p13+2p23+p33)-(p11+2p21+p31), Gy=(p31+2p32+p33)-(p11+2p12+p13), signed 11 bits, magnitude |Gx|+|Gy| unsigned 11 bits, no saturation.
REQ-025 SHALL output vga_rgb=16'hFFFF when magnitude >= EDGE_TH, else 16'h0000.
REQ-026 SHALL force vga_rgb=0 for rows 0-1 and columns 0-1 of each frame.
REQ-027 SHALL emit one vga_hys pulse per Y sample, fixed latency 4 clk cycles from the capturing din cycle; vga_vys SHALL be vsync delayed 4 cycles.
REQ-028 SHALL drive vga_rgb=0 whenever vga_hys=0.
REQ-029 SHALL ignore href asserted while vsync=1.

Reset
REQ-030 SHALL on rst_n low asynchronously clear: sio_c=1, sio_d=1, vga_hys=0, vga_vys=0, vga_rgb=0, cfg_done=0, capture disabled, debounce/SCCB/pixel counters zero, SCCB FSM idle.
REQ-031 SHALL on reset mid-SCCB-transfer abort immediately; the next press restarts at table entry 0.
REQ-032 xclk SHALL keep toggling during reset.

Verification
REQ-033 key_in low from 5 cycles after reset release, KEY_CNT_MAX=100 -> single press pulse at cycle 100 of the low period; SCCB start (sio_d falls, sio_c high) within SCCB_DIV cycles.
REQ-034 key_in bouncing every 50 cycles -> no SCCB activity.
REQ-035 Full config -> 8 writes decoded from sio_c/sio_d: first byte 0x42 each time, table pairs in order, then cfg_done.
REQ-036 Frame with uniform Y=0x80 after cfg_done -> all vga_rgb=0, vga_hys count = 640 x rows, 4-cycle latency.
REQ-037 Frame with vertical step Y=0x00 cols 0-319, 0xFF cols 320-639 -> vga_rgb=FFFF only at cols 320-321 for rows >=2.
REQ-038 Frame before key press -> vga_hys stays 0.

Source files
------------

// File: rtl/sobel_edge_detection.sv
// Camera front end: key-triggered SCCB register setup, Y-channel capture and a
// 3x3 Sobel edge detector producing a binary RGB565 pixel stream.
module sobel_edge_detection #(
    parameter int unsigned KEY_CNT_MAX = 500000,
    parameter int unsigned SCCB_DIV    = 250,
    parameter int unsigned EDGE_TH     = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_in,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  din,
    output logic        xclk,
    output logic        sio_c,
    output logic        sio_d,
    output logic        vga_hys,
    output logic        vga_vys,
    output logic [15:0] vga_rgb
);

    localparam int unsigned KEY_W   = $clog2(KEY_CNT_MAX + 1);
    localparam int unsigned DIV_W   = $clog2(SCCB_DIV);
    localparam int unsigned LINE_W  = 640;
    localparam int unsigned COL_W   = 10;
    localparam int unsigned ROW_W   = 10;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned G_W     = 11;
    localparam int unsigned FRAME_W = 27;
    localparam int unsigned LAT     = 4;

    localparam logic [DIV_W-1:0] DIV_Q1   = DIV_W'(SCCB_DIV / 4 - 1);
    localparam logic [DIV_W-1:0] DIV_H1   = DIV_W'(SCCB_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_Q3   = DIV_W'((3 * SCCB_DIV) / 4 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCCB_DIV - 1);
    localparam logic [4:0]       BIT_LAST = 5'(FRAME_W - 1);
    localparam logic [7:0]       SCCB_ID  = 8'h42;

    assign xclk = clk;

    // Key debounce: single pulse on the KEY_CNT_MAX-th consecutive low cycle
    logic [KEY_W-1:0] key_cnt;
    logic             press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_cnt <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_in) begin
                key_cnt <= '0;
            end else if (key_cnt != KEY_W'(KEY_CNT_MAX)) begin
                key_cnt <= key_cnt + KEY_W'(1);
                press   <= (key_cnt == KEY_W'(KEY_CNT_MAX - 1));
            end
        end
    end

    function automatic logic [15:0] cfg_entry(input logic [2:0] idx);
        logic [15:0] e;
        case (idx)
            3'd0:    e = 16'h1280;
            3'd1:    e = 16'h1101;
            3'd2:    e = 16'h1200;
            3'd3:    e = 16'h0C00;
            3'd4:    e = 16'h3E00;
            3'd5:    e = 16'h40D0;
            3'd6:    e = 16'h3A04;
            default: e = 16'h8C00;
        endcase
        return e;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_STOP
    } sccb_state_t;

    sccb_state_t          state, state_nxt;
    logic [DIV_W-1:0]     dcnt, dcnt_nxt;
    logic [4:0]           bcnt, bcnt_nxt;
    logic [2:0]           idx, idx_nxt;
    logic                 cfg_done, cfg_done_nxt;
    logic                 sio_c_nxt, sio_d_nxt;
    logic [15:0]          entry;
    logic [FRAME_W-1:0]   frame_bits;
    logic                 div_last;

    assign entry      = cfg_entry(idx);
    assign frame_bits = {SCCB_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    assign div_last   = (dcnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dcnt     <= '0;
            bcnt     <= '0;
            idx      <= '0;
            cfg_done <= 1'b0;
            sio_c    <= 1'b1;
            sio_d    <= 1'b1;
        end else begin
            state    <= state_nxt;
            dcnt     <= dcnt_nxt;
            bcnt     <= bcnt_nxt;
            idx      <= idx_nxt;
            cfg_done <= cfg_done_nxt;
            sio_c    <= sio_c_nxt;
            sio_d    <= sio_d_nxt;
        end
    end

    // SDA moves at the quarter point of a low SCL phase; SCL is high in the second half
    always_comb begin
        state_nxt    = state;
        dcnt_nxt     = div_last ? '0 : dcnt + DIV_W'(1);
        bcnt_nxt     = bcnt;
        idx_nxt      = idx;
        cfg_done_nxt = cfg_done;
        sio_c_nxt    = sio_c;
        sio_d_nxt    = sio_d;
        case (state)
            S_IDLE: begin
                dcnt_nxt  = '0;
                sio_c_nxt = 1'b1;
                sio_d_nxt = 1'b1;
                if (press) begin
                    state_nxt = S_START;
                    idx_nxt   = '0;
                    bcnt_nxt  = '0;
                end
            end
            S_START: begin
                sio_c_nxt = 1'b1;
                if (dcnt == DIV_H1) sio_d_nxt = 1'b0;
                if (div_last) begin
                    sio_c_nxt = 1'b0;
                    bcnt_nxt  = '0;
                    state_nxt = S_BITS;
                end
            end
            S_BITS: begin
                if (dcnt == DIV_Q1) sio_d_nxt = frame_bits[BIT_LAST - bcnt];
                if (dcnt == DIV_H1) sio_c_nxt = 1'b1;
                if (div_last) begin
                    sio_c_nxt = 1'b0;
                    if (bcnt == BIT_LAST) state_nxt = S_STOP;
                    else                  bcnt_nxt  = bcnt + 5'd1;
                end
            end
            S_STOP: begin
                if (dcnt == DIV_Q1) sio_d_nxt = 1'b0;
                if (dcnt == DIV_H1) sio_c_nxt = 1'b1;
                if (dcnt == DIV_Q3) sio_d_nxt = 1'b1;
                if (div_last) begin
                    if (idx == 3'd7) begin
                        cfg_done_nxt = 1'b1;
                        state_nxt    = S_IDLE;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = S_START;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture control: Y bytes on even href cycles once enabled by a vsync fall
    logic [LAT-1:0]   vs_pipe;
    logic             cap_en;
    logic             href_v, href_v_d;
    logic             byte_ph;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             sample;

    assign href_v = href & ~vsync;
    assign sample = cap_en & href_v & ~byte_ph & (col < COL_W'(LINE_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe  <= '0;
            cap_en   <= 1'b0;
            href_v_d <= 1'b0;
            byte_ph  <= 1'b0;
            col      <= '0;
            row      <= '0;
        end else begin
            vs_pipe  <= {vs_pipe[LAT-2:0], vsync};
            href_v_d <= href_v;
            if (cfg_done && vs_pipe[0] && !vsync) cap_en <= 1'b1;
            if (!href_v) begin
                byte_ph <= 1'b0;
                col     <= '0;
            end else begin
                byte_ph <= ~byte_ph;
                if (sample) col <= col + COL_W'(1);
            end
            if (vsync) begin
                row <= '0;
            end else if (href_v_d && !href_v && col != '0 && row != {ROW_W{1'b1}}) begin
                row <= row + ROW_W'(1);
            end
        end
    end

    // Two line buffers: lb0 holds the previous line, lb1 the one before it
    logic [PIX_W-1:0] lb0 [LINE_W];
    logic [PIX_W-1:0] lb1 [LINE_W];
    logic [PIX_W-1:0] top_q, mid_q;

    always_ff @(posedge clk) begin
        if (sample) begin
            lb0[col] <= din;
            lb1[col] <= lb0[col];
            mid_q    <= lb0[col];
            top_q    <= lb1[col];
        end
    end

    logic [PIX_W-1:0] y1;
    logic [PIX_W-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic             v1, v2, v3, v4;
    logic             bord1, bord2, bord3, bord4;
    logic signed [G_W-1:0] gx, gy;
    logic [G_W-1:0]   gx_pos, gx_neg, gy_pos, gy_neg;
    logic [G_W-1:0]   gx_abs, gy_abs, mag4;

    assign gx_pos = G_W'(p13) + G_W'({p23, 1'b0}) + G_W'(p33);
    assign gx_neg = G_W'(p11) + G_W'({p21, 1'b0}) + G_W'(p31);
    assign gy_pos = G_W'(p31) + G_W'({p32, 1'b0}) + G_W'(p33);
    assign gy_neg = G_W'(p11) + G_W'({p12, 1'b0}) + G_W'(p13);
    assign gx_abs = gx[G_W-1] ? G_W'(-gx) : G_W'(gx);
    assign gy_abs = gy[G_W-1] ? G_W'(-gy) : G_W'(gy);

    // Pipeline: capture, window shift, gradients, magnitude, output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1    <= '0;
            v1    <= 1'b0;
            bord1 <= 1'b0;
            {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
            v2    <= 1'b0;
            bord2 <= 1'b0;
            gx    <= '0;
            gy    <= '0;
            v3    <= 1'b0;
            bord3 <= 1'b0;
            mag4  <= '0;
            v4    <= 1'b0;
            bord4 <= 1'b0;
        end else begin
            y1    <= din;
            v1    <= sample;
            bord1 <= (row < ROW_W'(2)) || (col < COL_W'(2));
            if (v1) begin
                p11 <= p12;  p12 <= p13;  p13 <= top_q;
                p21 <= p22;  p22 <= p23;  p23 <= mid_q;
                p31 <= p32;  p32 <= p33;  p33 <= y1;
            end
            v2    <= v1;
            bord2 <= bord1;
            gx    <= $signed(gx_pos - gx_neg);
            gy    <= $signed(gy_pos - gy_neg);
            v3    <= v2;
            bord3 <= bord2;
            mag4  <= gx_abs + gy_abs;
            v4    <= v3;
            bord4 <= bord3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hys <= 1'b0;
            vga_vys <= 1'b0;
            vga_rgb <= '0;
        end else begin
            vga_hys <= v4;
            vga_vys <= vs_pipe[LAT-1];
            vga_rgb <= (v4 && !bord4 && mag4 >= G_W'(EDGE_TH)) ? 16'hFFFF : 16'h0000;
        end
    end

endmodule

// File: tb/tb_sobel_edge_detection.sv
// Bench for sobel_edge_detection: SCCB decode against the register table and
// pixel output checked against a frame-level Sobel model.
`timescale 1ns/1ps
module tb_sobel_edge_detection;

    localparam int KEY_MAX = 100;
    localparam int DIV     = 20;
    localparam int TH      = 100;
    localparam int W       = 640;
    localparam int ROWS    = 5;

    logic        clk = 1'b0;
    logic        rst_n, key_in, vsync, href;
    logic [7:0]  din;
    logic        xclk, sio_c, sio_d, vga_hys, vga_vys;
    logic [15:0] vga_rgb;

    sobel_edge_detection #(.KEY_CNT_MAX(KEY_MAX), .SCCB_DIV(DIV), .EDGE_TH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .vsync(vsync), .href(href), .din(din),
        .xclk(xclk), .sio_c(sio_c), .sio_d(sio_d),
        .vga_hys(vga_hys), .vga_vys(vga_vys), .vga_rgb(vga_rgb)
    );

    always #20 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] tbl_reg [8] = '{8'h12, 8'h11, 8'h12, 8'h0C, 8'h3E, 8'h40, 8'h3A, 8'h8C};
    logic [7:0] tbl_val [8] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'hD0, 8'h04, 8'h00};

    logic [7:0] img [ROWS][W];

    typedef struct {
        logic [15:0] rgb;
        int          t;
    } exp_t;
    exp_t q[$];

    function automatic logic [15:0] exp_pix(input int r, input int c);
        int gx, gy, mag;
        if (r < 2 || c < 2) return 16'h0000;
        gx = (int'(img[r-2][c]) + 2 * int'(img[r-1][c]) + int'(img[r][c]))
           - (int'(img[r-2][c-2]) + 2 * int'(img[r-1][c-2]) + int'(img[r][c-2]));
        gy = (int'(img[r][c-2]) + 2 * int'(img[r][c-1]) + int'(img[r][c]))
           - (int'(img[r-2][c-2]) + 2 * int'(img[r-2][c-1]) + int'(img[r-2][c]));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag >= TH) ? 16'hFFFF : 16'h0000;
    endfunction

    // Output monitor: pixel order, value, latency and frame-sync delay
    logic [4:0] vs_hist;
    bit         mon_en = 0;
    int         hys_cnt = 0;
    always @(posedge clk) begin
        exp_t e;
        vs_hist = {vs_hist[3:0], vsync};
        #1;
        if (mon_en) begin
            chk("vga_vys", 32'(vga_vys), 32'(vs_hist[4]));
            if (vga_hys) begin
                hys_cnt++;
                chk("hys_queued", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("pix_rgb", 32'(vga_rgb), 32'(e.rgb));
                    chk("pix_latency", cyc, e.t);
                end
            end else begin
                chk("rgb_idle", 32'(vga_rgb), 0);
            end
        end
    end

    // SCCB decoder working from the bus waveforms alone
    bit          prev_c = 1, prev_d = 1, in_x = 0;
    int          n_start = 0, n_wr = 0, nbits = 0;
    logic [27:0] sh;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (prev_c && sio_c && prev_d && !sio_d) begin
                n_start++;
                in_x  = 1;
                nbits = 0;
                sh    = '0;
            end else if (prev_c && sio_c && !prev_d && sio_d) begin
                if (in_x && n_wr < 8) begin
                    chk("sccb_nbits", nbits, 28);
                    chk("sccb_id", 32'(sh[27:20]), 32'h42);
                    chk("sccb_reg", 32'(sh[18:11]), 32'(tbl_reg[n_wr]));
                    chk("sccb_val", 32'(sh[9:2]), 32'(tbl_val[n_wr]));
                    chk("sccb_dontcare", 32'({sh[19], sh[10], sh[1]}), 32'h7);
                end
                if (in_x) n_wr++;
                in_x = 0;
            end else if (!prev_c && sio_c) begin
                sh = {sh[26:0], sio_d};
                nbits++;
            end else if (sio_d !== prev_d) begin
                chk("sda_moves_scl_low", 32'({prev_c, sio_c}), 0);
            end
        end
        prev_c = sio_c;
        prev_d = sio_d;
    end

    task automatic drive_frame(input int rows, input bit expect_out);
        vsync = 1'b1; href = 1'b0;
        repeat (5) @(negedge clk);
        href = 1'b1;
        repeat (10) begin din = 8'($urandom); @(negedge clk); end
        href = 1'b0;
        repeat (5) @(negedge clk);
        vsync = 1'b0;
        repeat (10) @(negedge clk);
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < 2 * W; b++) begin
                href = 1'b1;
                if (b % 2 == 0) begin
                    din = img[r][b/2];
                    if (expect_out) q.push_back('{rgb: exp_pix(r, b/2), t: cyc + 5});
                end else begin
                    din = 8'($urandom);
                end
                @(negedge clk);
            end
            href = 1'b0; din = 8'h00;
            repeat (20) @(negedge clk);
        end
        vsync = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int rows);
        chk({tag, "_hys_count"}, hys_cnt, W * rows);
        chk({tag, "_queue_empty"}, q.size(), 0);
    endtask

    initial begin
        #(90000 * 40);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, k;
        rst_n = 1'b0; key_in = 1'b1; vsync = 1'b1; href = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sio_c", 32'(sio_c), 1);
        chk("rst_sio_d", 32'(sio_d), 1);
        chk("rst_hys", 32'(vga_hys), 0);
        chk("rst_vys", 32'(vga_vys), 0);
        chk("rst_rgb", 32'(vga_rgb), 0);
        chk("xclk_low_in_rst", 32'(xclk), 32'(clk));
        @(posedge clk); #1;
        chk("xclk_high_in_rst", 32'(xclk), 32'(clk));
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        mon_en = 1;

        // Bouncing key never reaches the stable count
        for (int i = 0; i < 12; i++) begin
            key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (50) @(negedge clk);
        end
        key_in = 1'b1;
        repeat (300) @(negedge clk);
        chk("bounce_no_start", n_start, 0);
        chk("bounce_sio_c_idle", 32'(sio_c), 1);
        chk("bounce_sio_d_idle", 32'(sio_d), 1);

        // Frame before any configuration produces no output
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
        hys_cnt = 0;
        drive_frame(ROWS, 0);
        chk("precfg_hys_count", hys_cnt, 0);

        // Fresh reset, press 5 cycles after release
        mon_en = 0;
        @(negedge clk) rst_n = 1'b0;
        in_x = 0; n_start = 0; n_wr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1;
        key_in = 1'b0;
        t0 = cyc;
        k = 0;
        while (n_start == 0 && k < KEY_MAX + DIV + 20) begin @(posedge clk); #2; k++; end
        chk("press_start_seen", n_start, 1);
        chk("press_start_after_debounce", 32'((cyc - t0) > KEY_MAX), 1);
        chk("press_start_within_div", 32'((cyc - t0) <= KEY_MAX + DIV), 1);
        chk("start_scl_high", 32'(sio_c), 1);
        repeat (200) @(negedge clk);
        key_in = 1'b1;

        // Abort in the middle of the third write
        k = 0;
        while (n_wr < 2 && k < 6000) begin @(negedge clk); k++; end
        chk("two_writes_before_abort", n_wr, 2);
        repeat (100) @(negedge clk);
        mon_en = 0;
        rst_n = 1'b0;
        in_x = 0;
        #1;
        chk("abort_sio_c", 32'(sio_c), 1);
        chk("abort_sio_d", 32'(sio_d), 1);
        n_start = 0; n_wr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1;
        repeat (50) @(negedge clk);
        chk("abort_stays_idle", n_start, 0);

        // Full configuration from table entry 0
        key_in = 1'b0;
        repeat (150) @(negedge clk);
        key_in = 1'b1;
        k = 0;
        while (n_wr < 8 && k < 8000) begin @(negedge clk); k++; end
        chk("cfg_writes", n_wr, 8);
        repeat (300) @(negedge clk);
        chk("cfg_no_extra_writes", n_wr, 8);
        chk("cfg_start_count", n_start, 8);

        // Uniform frame: no edges anywhere
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'h80;
        hys_cnt = 0;
        drive_frame(ROWS, 1);
        check_frame("uniform", ROWS);

        // Vertical step at column 320
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < W; c++) img[r][c] = (c < 320) ? 8'h00 : 8'hFF;
        chk("step_model_edge", 32'(exp_pix(2, 320)), 32'hFFFF);
        chk("step_model_flat", 32'(exp_pix(2, 322)), 32'h0000);
        hys_cnt = 0;
        drive_frame(ROWS, 1);
        check_frame("step", ROWS);

        // Random low-contrast texture straddling the threshold
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 50));
        hys_cnt = 0;
        drive_frame(ROWS, 1);
        check_frame("random", ROWS);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
